// File: rtl/bullet_pool_ctrl.sv
// Four-slot bullet pool: fire edge allocation, per-tick flight, hit release
// and a registered one-pixel-wide bullet renderer for the VGA pipeline.
module bullet_pool_ctrl #(
    parameter int         NUM_SLOTS  = 4,
    parameter logic [9:0] START_Y    = 10'd440,
    parameter logic [9:0] STEP       = 10'd4,
    parameter logic [7:0] COOLDOWN   = 8'd20,
    parameter logic [9:0] BULLET_LEN = 10'd16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fire,
    input  logic                 move_tick,
    input  logic [9:0]           player_pos,
    input  logic                 hit,
    input  logic [1:0]           hit_slot,
    input  logic [9:0]           hor_cnt,
    input  logic [9:0]           ver_cnt,
    output logic                 fire_ack,
    output logic [1:0]           fire_slot,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [5:0]           rgb_content,
    output logic [1:0]           pix_slot
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_FLIGHT = 1'b1
    } slot_state_t;

    slot_state_t r_state [NUM_SLOTS];
    slot_state_t w_state_nxt [NUM_SLOTS];
    logic [9:0]  r_x [NUM_SLOTS];
    logic [9:0]  r_y [NUM_SLOTS];
    logic [9:0]  w_x_nxt [NUM_SLOTS];
    logic [9:0]  w_y_nxt [NUM_SLOTS];

    logic [7:0]  r_cool;
    logic [7:0]  w_cool_nxt;
    logic        r_fire_q;
    logic        r_armed;
    logic        r_fire_ack;
    logic [1:0]  r_fire_slot;
    logic [5:0]  r_rgb;
    logic [1:0]  r_pix_slot;

    logic        w_req;
    logic        w_any_idle;
    logic        w_accept;
    logic [1:0]  w_alloc;
    logic [NUM_SLOTS-1:0] w_match;
    logic        w_any_match;
    logic [1:0]  w_pix;

    // Allocation looks only at start-of-cycle state, so slots freed this
    // cycle are never handed out until the next one.
    always_comb begin
        w_any_idle = 1'b0;
        w_alloc    = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_state[i] == S_IDLE) begin
                w_any_idle = 1'b1;
                w_alloc    = 2'(i);
            end
        end
        w_req    = fire & ~r_fire_q & r_armed;
        w_accept = w_req & (r_cool == 8'd0) & w_any_idle;
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_x_nxt[i]     = r_x[i];
            w_y_nxt[i]     = r_y[i];
            if (w_accept && (w_alloc == 2'(i))) begin
                w_state_nxt[i] = S_FLIGHT;
                w_x_nxt[i]     = player_pos;
                w_y_nxt[i]     = START_Y;
            end else if (r_state[i] == S_FLIGHT) begin
                if (hit && (hit_slot == 2'(i))) begin
                    w_state_nxt[i] = S_IDLE;
                end else if (move_tick) begin
                    if (r_y[i] < STEP) begin
                        w_state_nxt[i] = S_IDLE;
                    end else begin
                        w_y_nxt[i] = r_y[i] - STEP;
                    end
                end
            end
        end
    end

    always_comb begin
        w_cool_nxt = r_cool;
        if (w_accept) begin
            w_cool_nxt = COOLDOWN;
        end else if (move_tick && (r_cool != 8'd0)) begin
            w_cool_nxt = r_cool - 8'd1;
        end
    end

    // Compare in 11 bits so x+1 and y+len-1 cannot wrap past 1023.
    always_comb begin
        w_pix       = 2'd0;
        w_any_match = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            w_match[i] = (r_state[i] == S_FLIGHT)
                && ({1'b0, hor_cnt} == ({1'b0, r_x[i]} + 11'd1))
                && ({1'b0, r_y[i]} <= {1'b0, ver_cnt})
                && ({1'b0, ver_cnt} <=
                    ({1'b0, r_y[i]} + {1'b0, BULLET_LEN} - 11'd1));
            if (w_match[i]) begin
                w_pix       = 2'(i);
                w_any_match = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= S_IDLE;
                r_x[i]     <= 10'd0;
                r_y[i]     <= 10'd0;
            end
            r_cool      <= 8'd0;
            r_fire_q    <= 1'b0;
            r_armed     <= 1'b0;
            r_fire_ack  <= 1'b0;
            r_fire_slot <= 2'd0;
            r_rgb       <= 6'b000000;
            r_pix_slot  <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_x[i]     <= w_x_nxt[i];
                r_y[i]     <= w_y_nxt[i];
            end
            r_cool   <= w_cool_nxt;
            r_fire_q <= fire;
            // A button held through reset must be released before it counts.
            if (!fire) begin
                r_armed <= 1'b1;
            end
            r_fire_ack <= w_accept;
            if (w_accept) begin
                r_fire_slot <= w_alloc;
            end
            r_rgb      <= w_any_match ? 6'b111111 : 6'b000000;
            r_pix_slot <= w_pix;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_active[i] = (r_state[i] == S_FLIGHT);
        end
    end

    assign fire_ack    = r_fire_ack;
    assign fire_slot   = r_fire_slot;
    assign rgb_content = r_rgb;
    assign pix_slot    = r_pix_slot;

endmodule

// File: doc/bullet_pool_ctrl.md
BULLET_POOL_CTRL -- requirements
Module: bullet_pool_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of concurrent bullet slots (fixed 4; slot index 2 bits).
REQ-002 SHALL have parameter START_Y, default 10'd440, Y loaded into a newly fired bullet.
REQ-003 SHALL have parameter STEP, default 10'd4, pixels a bullet rises per move_tick.
REQ-004 SHALL have parameter COOLDOWN, default 8'd20, move_ticks between accepted shots.
REQ-005 SHALL have parameter BULLET_LEN, default 10'd16, bullet height in lines.
REQ-006 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port fire  input  1  fire pushbutton level, active-high, synchronous to clk.
REQ-009 SHALL have port move_tick  input  1  one-cycle pulse advancing bullets and cooldown.
REQ-010 SHALL have port player_pos  input  10  player X at time of shot.
REQ-011 SHALL have port hit  input  1  one-cycle pulse: bullet in hit_slot collided.
REQ-012 SHALL have port hit_slot  input  2  slot index qualified by hit.
REQ-013 SHALL have port hor_cnt  input  10  current pixel X from VGA timing.
REQ-014 SHALL have port ver_cnt  input  10  current pixel Y from VGA timing.
REQ-015 SHALL have port fire_ack  output  1  one-cycle pulse: shot accepted.
REQ-016 SHALL have port fire_slot  output  2  slot allocated, valid with fire_ack.
REQ-017 SHALL have port slot_active  output  4  per-slot in-flight flags.
REQ-018 SHALL have port rgb_content  output  6  bullet pixel colour, 6'b111111 or 6'b000000.
REQ-019 SHALL have port pix_slot  output  2  lowest-index slot drawn at current pixel.

Function
REQ-020 Each slot SHALL hold x[9:0], y[9:0] and a two-state FSM: IDLE, FLIGHT (slot_active=1 iff FLIGHT).
REQ-021 fire SHALL be registered once and rising-edge detected; only the edge cycle is a fire request; held fire never repeats.
REQ-022 A fire request SHALL be accepted iff cooldown==0 and at least one slot is IDLE at the start of the cycle.
REQ-023 On accept, next edge: lowest-index IDLE slot -> FLIGHT, x<=player_pos, y<=START_Y, cooldown<=COOLDOWN, fire_ack=1 for one cycle, fire_slot=that index.
REQ-024 A rejected request SHALL be dropped with no state change and fire_ack=0; it is not queued.
REQ-025 On move_tick each FLIGHT slot SHALL do: if y < STEP then -> IDLE (no underflow), else y<=y-STEP.
REQ-026 On move_tick cooldown SHALL decrement by 1 when nonzero and saturate at 0.
REQ-027 On hit the slot hit_slot SHALL go IDLE next edge; hit on an IDLE slot SHALL be ignored.
REQ-028 hit and move_tick same cycle on same slot: hit wins, slot -> IDLE.
REQ-029 A slot freed by hit/move in a cycle SHALL NOT be allocated by a fire request in that same cycle.
REQ-030 A slot allocated in a cycle SHALL NOT be moved by a coincident move_tick (y==START_Y after).
REQ-031 Accept and move_tick same cycle: cooldown loads COOLDOWN (load beats decrement).
REQ-032 x and y of IDLE slots SHALL hold their last values.
REQ-033 Render: pixel match for a FLIGHT slot iff hor_cnt==x+1 and y <= ver_cnt <= y+BULLET_LEN-1, compare in 11-bit to avoid wrap.
REQ-034 rgb_content SHALL be registered, 1-cycle latency from hor_cnt/ver_cnt: 6'b111111 if any slot matches, else 6'b000000; pix_slot = lowest matching index, 0 when none.

Reset
REQ-035 While reset=0: all slots IDLE, x=0, y=0, cooldown=0, fire edge register=0, fire_ack=0, fire_slot=0, slot_active=4'b0000, rgb_content=6'b000000, pix_slot=0.
REQ-036 Reset asserted mid-flight SHALL clear all slots immediately (asynchronous); after release a held fire SHALL NOT fire until released and re-pressed.

Verification
REQ-037 Reset release, fire 0->1 with player_pos=100 -> fire_ack one cycle, fire_slot=0, slot 0 x=100 y=440, slot_active=4'b0001.
REQ-038 Second fire edge 5 move_ticks later -> rejected (cooldown=15); fire edge after 20 move_ticks -> accepted into slot 1.
REQ-039 Four shots 20 ticks apart, then a fifth -> fifth rejected, slot_active=4'b1111; hit with hit_slot=2 then fire edge after cooldown -> slot 2 reused.
REQ-040 Slot at y=4, move_tick -> y=0; next move_tick -> IDLE; y=3, move_tick -> IDLE directly.
REQ-041 Slot 0 x=100 y=200: hor_cnt=101, ver_cnt=200..215 -> rgb_content=6'b111111 one cycle later; ver_cnt=216 or hor_cnt=100 -> 6'b000000.
REQ-042 hit on slot 0 coincident with fire edge, all 4 slots full, cooldown 0 -> fire rejected, slot 0 IDLE.
